// File: rtl/raisin64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raisin64_pkg
// Brief    : Shared raisin64 widths, writeback source indices and entry type.
// Revision : 1.0 - initial release
// ============================================================================
package raisin64_pkg;

    localparam int unsigned c_data_w  = 64;
    localparam int unsigned c_rn_w    = 6;
    localparam int unsigned c_num_src = 3;

    // Writeback source indices, also the round-robin visiting order.
    localparam logic [1:0] c_src_alu = 2'd0;
    localparam logic [1:0] c_src_mul = 2'd1;
    localparam logic [1:0] c_src_mem = 2'd2;

    // One pending register-file write.
    typedef struct packed {
        logic [c_rn_w-1:0]   rn;
        logic [c_data_w-1:0] data;
    } wb_entry_t;

    // Source index that follows idx in round-robin order (wraps MEM -> ALU).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == c_src_mem) ? c_src_alu : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Per-source writeback queue. Registered ready (not-full after the
//            edge), simultaneous push and pop both take effect.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import raisin64_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(wb_entry_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int unsigned    c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic [c_aw:0]    w_count_nxt;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;

    // The push is only honoured when the source saw ready high this cycle.
    assign w_push  = i_push && r_ready;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rptr];

    // Occupancy after this edge; drives the registered ready.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointers, occupancy and ready; ready stays low while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_full);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Three-source register-file writeback arbiter. One queue per
//            source, round-robin grant, one registered write per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import raisin64_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic                mul_valid,
    input  logic                mem_valid,
    output logic                alu_ready,
    output logic                mul_ready,
    output logic                mem_ready,
    input  logic [c_rn_w-1:0]   alu_rn,
    input  logic [c_rn_w-1:0]   mul_rn,
    input  logic [c_rn_w-1:0]   mem_rn,
    input  logic [c_data_w-1:0] alu_data,
    input  logic [c_data_w-1:0] mul_data,
    input  logic [c_data_w-1:0] mem_data,
    output logic                w_en,
    output logic [c_rn_w-1:0]   w_rn,
    output logic [c_data_w-1:0] w_data,
    output logic                wb_idle
);

    logic [c_num_src-1:0] w_src_valid;
    logic [c_num_src-1:0] w_src_push;
    logic [c_num_src-1:0] w_src_ready;
    logic [c_num_src-1:0] w_pop;
    logic [c_num_src-1:0] w_empty;
    wb_entry_t            w_src_entry [c_num_src];
    wb_entry_t            w_q_head    [c_num_src];

    logic                 w_gnt_vld;
    logic [1:0]           w_gnt_idx;
    wb_entry_t            w_gnt_entry;

    logic [1:0]           r_ptr;
    logic                 r_w_en;
    logic [c_rn_w-1:0]    r_w_rn;
    logic [c_data_w-1:0]  r_w_data;

    assign w_src_valid[c_src_alu] = alu_valid;
    assign w_src_valid[c_src_mul] = mul_valid;
    assign w_src_valid[c_src_mem] = mem_valid;
    assign w_src_entry[c_src_alu] = '{rn: alu_rn, data: alu_data};
    assign w_src_entry[c_src_mul] = '{rn: mul_rn, data: mul_data};
    assign w_src_entry[c_src_mem] = '{rn: mem_rn, data: mem_data};

    assign alu_ready = w_src_ready[c_src_alu];
    assign mul_ready = w_src_ready[c_src_mul];
    assign mem_ready = w_src_ready[c_src_mem];

    // One queue per source. Writes to r0 complete the handshake but are
    // never enqueued, since r0 is hardwired and must not be written.
    generate
        for (genvar g = 0; g < c_num_src; g++) begin : g_fifo
            assign w_src_push[g] = w_src_valid[g] && (w_src_entry[g].rn != '0);

            wb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH ($bits(wb_entry_t))
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_src_push[g]),
                .o_ready (w_src_ready[g]),
                .i_data  (w_src_entry[g]),
                .i_pop   (w_pop[g]),
                .o_data  (w_q_head[g]),
                .o_empty (w_empty[g])
            );
        end
    endgenerate

    // Round-robin pick: first non-empty queue at or after the pointer.
    always_comb begin
        w_gnt_vld = ~&w_empty;
        w_gnt_idx = r_ptr;
        case (r_ptr)
            c_src_alu: w_gnt_idx = !w_empty[0] ? c_src_alu : (!w_empty[1] ? c_src_mul : c_src_mem);
            c_src_mul: w_gnt_idx = !w_empty[1] ? c_src_mul : (!w_empty[2] ? c_src_mem : c_src_alu);
            default:   w_gnt_idx = !w_empty[2] ? c_src_mem : (!w_empty[0] ? c_src_alu : c_src_mul);
        endcase
    end

    assign w_pop = w_gnt_vld ? (3'b001 << w_gnt_idx) : 3'b000;

    // Head of the granted queue.
    always_comb begin
        w_gnt_entry = w_q_head[0];
        case (w_gnt_idx)
            c_src_mul: w_gnt_entry = w_q_head[1];
            c_src_mem: w_gnt_entry = w_q_head[2];
            default:   w_gnt_entry = w_q_head[0];
        endcase
    end

    // Output register and pointer; rn/data hold their value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= c_src_alu;
            r_w_en   <= 1'b0;
            r_w_rn   <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_w_rn   <= w_gnt_entry.rn;
                r_w_data <= w_gnt_entry.data;
                r_ptr    <= rr_next(w_gnt_idx);
            end
        end
    end

    assign w_en    = r_w_en;
    assign w_rn    = r_w_rn;
    assign w_data  = r_w_data;
    assign wb_idle = (&w_empty) && !r_w_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter: vector table, directed
//            multi-cycle sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import raisin64_pkg::*;

    localparam int unsigned c_depth = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  v   = 3'b000;
    logic [5:0]  rn  [3];
    logic [63:0] dat [3];
    logic        alu_ready, mul_ready, mem_ready, w_en, wb_idle;
    logic [5:0]  w_rn;
    logic [63:0] w_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one plain queue per source plus a rotating pointer.
    wb_entry_t   mq [3][$];
    int          m_ptr;
    logic        exp_en;
    logic [5:0]  exp_rn;
    logic [63:0] exp_data;
    logic [2:0]  exp_rdy;
    logic        exp_idle;

    typedef struct packed {
        logic [2:0]  v;
        logic [5:0]  r0, r1, r2;
        logic [63:0] d0, d1, d2;
        logic        en;
        logic [5:0]  ern;
        logic [63:0] edata;
        logic [2:0]  erdy;
        logic        eidle;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(c_depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (v[0]),
        .mul_valid (v[1]),
        .mem_valid (v[2]),
        .alu_ready (alu_ready),
        .mul_ready (mul_ready),
        .mem_ready (mem_ready),
        .alu_rn    (rn[0]),
        .mul_rn    (rn[1]),
        .mem_rn    (rn[2]),
        .alu_data  (dat[0]),
        .mul_data  (dat[1]),
        .mem_data  (dat[2]),
        .w_en      (w_en),
        .w_rn      (w_rn),
        .w_data    (w_data),
        .wb_idle   (wb_idle)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".w_en"},  w_en, exp_en);
        check({tag, ".w_rn"},  w_rn, exp_rn);
        check({tag, ".w_data"}, w_data, exp_data);
        check({tag, ".ready"}, {mem_ready, mul_ready, alu_ready}, exp_rdy);
        check({tag, ".idle"},  wb_idle, exp_idle);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_ptr    = 0;
        exp_en   = 1'b0;
        exp_rn   = '0;
        exp_data = '0;
        exp_rdy  = 3'b000;
        exp_idle = 1'b1;
    endtask

    // Effect of one rising edge, using the inputs and ready seen before it.
    task automatic model_edge();
        int        g;
        wb_entry_t e;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_ptr + k) % 3;
            if (g < 0 && mq[s].size() > 0) g = s;
        end
        if (g >= 0) begin
            e        = mq[g].pop_front();
            exp_en   = 1'b1;
            exp_rn   = e.rn;
            exp_data = e.data;
            m_ptr    = (g + 1) % 3;
        end else begin
            exp_en = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i] && exp_rdy[i] && rn[i] != 6'd0) mq[i].push_back('{rn: rn[i], data: dat[i]});
        end
        for (int i = 0; i < 3; i++) exp_rdy[i] = (mq[i].size() < c_depth);
        exp_idle = (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0) && !exp_en;
    endtask

    task automatic step(input logic [2:0] sv, input logic [5:0] r0, input logic [5:0] r1,
                        input logic [5:0] r2, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input string tag);
        v = sv; rn[0] = r0; rn[1] = r1; rn[2] = r2; dat[0] = d0; dat[1] = d1; dat[2] = d2;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(3'b000, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        v = 3'b000;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(3'b000, 0, 0, 0, 0, 0, 0, "release");
    endtask

    function automatic logic [5:0] rand_rn();
        return ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    endfunction

    int          k, writes, consec, last, s;
    int          cnt [3];
    logic        acc, saw_low;
    logic [63:0] alu_seen [$];

    initial begin
        for (int i = 0; i < 3; i++) begin rn[i] = '0; dat[i] = '0; end
        model_reset();

        // ---------------- vector table ----------------
        tbl[0]  = '{3'b111, 6'd1, 6'd2, 6'd3, 64'h11, 64'h22, 64'h33,   1'b0, 6'd0, 64'h0,    3'b111, 1'b0};
        tbl[1]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b1, 6'd1, 64'h11,   3'b111, 1'b0};
        tbl[2]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b1, 6'd2, 64'h22,   3'b111, 1'b0};
        tbl[3]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b1, 6'd3, 64'h33,   3'b111, 1'b0};
        tbl[4]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b0, 6'd3, 64'h33,   3'b111, 1'b1};
        tbl[5]  = '{3'b001, 6'd5, 6'd0, 6'd0, 64'hDEAD, 64'h0, 64'h0,   1'b0, 6'd3, 64'h33,   3'b111, 1'b0};
        tbl[6]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b1, 6'd5, 64'hDEAD, 3'b111, 1'b0};
        tbl[7]  = '{3'b100, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'hFFFF, 1'b0, 6'd5, 64'hDEAD, 3'b111, 1'b1};
        tbl[8]  = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b0, 6'd5, 64'hDEAD, 3'b111, 1'b1};
        tbl[9]  = '{3'b011, 6'd7, 6'd8, 6'd0, 64'h77, 64'h88, 64'h0,    1'b0, 6'd5, 64'hDEAD, 3'b111, 1'b0};
        tbl[10] = '{3'b001, 6'd9, 6'd0, 6'd0, 64'h99, 64'h0,  64'h0,    1'b1, 6'd8, 64'h88,   3'b110, 1'b0};
        tbl[11] = '{3'b001, 6'd10, 6'd0, 6'd0, 64'hAA, 64'h0, 64'h0,    1'b1, 6'd7, 64'h77,   3'b111, 1'b0};
        tbl[12] = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b1, 6'd9, 64'h99,   3'b111, 1'b0};
        tbl[13] = '{3'b000, 6'd0, 6'd0, 6'd0, 64'h0,  64'h0,  64'h0,    1'b0, 6'd9, 64'h99,   3'b111, 1'b1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            v = tbl[i].v;
            rn[0] = tbl[i].r0;  rn[1] = tbl[i].r1;  rn[2] = tbl[i].r2;
            dat[0] = tbl[i].d0; dat[1] = tbl[i].d1; dat[2] = tbl[i].d2;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d.w_en", i),   w_en, tbl[i].en);
            check($sformatf("tbl%0d.w_rn", i),   w_rn, tbl[i].ern);
            check($sformatf("tbl%0d.w_data", i), w_data, tbl[i].edata);
            check($sformatf("tbl%0d.ready", i),  {mem_ready, mul_ready, alu_ready}, tbl[i].erdy);
            check($sformatf("tbl%0d.idle", i),   wb_idle, tbl[i].eidle);
        end

        // ---------------- back-pressure: ALU 1..4 against saturated MUL/MEM ----------------
        do_reset();
        k = 1;
        saw_low = 1'b0;
        for (int c = 0; c < 40 && k <= 4; c++) begin
            acc = alu_ready;
            if (!alu_ready) saw_low = 1'b1;
            step(3'b111, 6'(k), 6'd2, 6'd3, 64'hA000 + 64'(k), 64'hB000, 64'hC000, "bp");
            if (w_en && w_data[15:12] == 4'hA) alu_seen.push_back(w_data);
            if (acc) k++;
        end
        check("bp.accepted", 64'(k), 64'd5);
        for (int c = 0; c < 12; c++) begin
            step(3'b000, 0, 0, 0, 0, 0, 0, "bp_drain");
            if (w_en && w_data[15:12] == 4'hA) alu_seen.push_back(w_data);
        end
        check("bp.ready_drop", saw_low, 1'b1);
        check("bp.alu_count", 64'(alu_seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp.order%0d", i), (i < alu_seen.size()) ? alu_seen[i] : 64'hX,
                  64'hA000 + 64'(i + 1));
        end

        // ---------------- fairness: all valids held ----------------
        do_reset();
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        writes = 0; consec = 0; last = -1;
        for (int c = 0; c < 60 && writes < 30; c++) begin
            step(3'b111, 6'd1, 6'd2, 6'd3, 64'h1, 64'h2, 64'h3, "fair");
            if (w_en) begin
                s = int'(w_rn) - 1;
                if (s >= 0 && s < 3) cnt[s]++;
                if (s == last) consec++;
                last = s;
                writes++;
            end
        end
        check("fair.writes", 64'(writes), 64'd30);
        check("fair.alu", 64'(cnt[0]), 64'd10);
        check("fair.mul", 64'(cnt[1]), 64'd10);
        check("fair.mem", 64'(cnt[2]), 64'd10);
        check("fair.consecutive", 64'(consec), 64'd0);
        idle_steps(8, "fair_drain");

        // ---------------- reset mid-burst with 5 entries queued ----------------
        step(3'b111, 6'd1, 6'd2, 6'd3, 64'h101, 64'h102, 64'h103, "burst");
        step(3'b111, 6'd4, 6'd5, 6'd6, 64'h104, 64'h105, 64'h106, "burst");
        rst = 1'b1;
        #1;
        check("midrst.w_en",   w_en, 1'b0);
        check("midrst.w_rn",   w_rn, 6'd0);
        check("midrst.w_data", w_data, 64'd0);
        check("midrst.ready",  {mem_ready, mul_ready, alu_ready}, 3'b000);
        check("midrst.idle",   wb_idle, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_steps(6, "post_rst");

        // ---------------- random traffic ----------------
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(3'($urandom_range(0, 7)), rand_rn(), rand_rn(), rand_rn(),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "rand");
        end
        idle_steps(8, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, entries per source queue (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports alu_valid/mul_valid/mem_valid  input  1 each  source result present.
REQ-005 SHALL have ports alu_ready/mul_ready/mem_ready  output  1 each  source queue can accept.
REQ-006 SHALL have ports alu_rn/mul_rn/mem_rn  input  6 each  destination register number.
REQ-007 SHALL have ports alu_data/mul_data/mem_data  input  64 each  result value.
REQ-008 SHALL have port w_en  output  1  register-file write enable.
REQ-009 SHALL have port w_rn  output  6  register-file write register number.
REQ-010 SHALL have port w_data  output  64  register-file write data.
REQ-011 SHALL have port wb_idle  output  1  all queues empty and w_en low.

Function
REQ-012 SHALL accept a source transfer on a rising edge where that source's valid and ready are both high.
REQ-013 SHALL drive each x_ready high exactly when that source queue is not full, registered, with no same-cycle pop pass-through.
REQ-014 SHALL discard accepted transfers with rn==0 (no enqueue, no write), while still completing the handshake.
REQ-015 SHALL keep each source queue FIFO-ordered; a push and a pop on the same edge SHALL both take effect.
REQ-016 SHALL grant at most one non-empty queue per cycle, round-robin in order ALU(0), MUL(1), MEM(2), starting from the pointer.
REQ-017 SHALL move the round-robin pointer to (granted index + 1) mod 3 after each grant and leave it unchanged when nothing is granted.
REQ-018 SHALL pop the granted entry and register it into w_rn/w_data with w_en=1 on the same edge; w_en=0 on edges with no grant.
REQ-019 SHALL hold w_rn/w_data at their last values when w_en=0.
REQ-020 SHALL give a 2-edge latency: accepted at edge N with no contention -> w_en high during the cycle after edge N+1.
REQ-021 SHALL sustain one write per cycle while any queue is non-empty.
REQ-022 SHALL preserve write order only within a source; same-rn writes from different sources SHALL retire in grant order.
REQ-023 SHALL drive wb_idle combinationally from queue-empty flags and w_en.

Reset
REQ-024 SHALL, while rst is high, clear all queues, set the pointer to 0, and drive w_en=0, w_rn=0, w_data=0, all x_ready=0, wb_idle=1.
REQ-025 SHALL drive all x_ready high on the first edge after rst deasserts.
REQ-026 SHALL discard queued and in-flight entries when rst asserts mid-operation, with no spurious w_en after release.

Structure
REQ-027 SHALL take data width 64, rn width 6, and source indices ALU/MUL/MEM from the shared raisin64 package.
REQ-028 SHALL implement each source queue as one sub-module, wb_fifo, instantiated three times.
REQ-029 SHALL contain only the arbiter, pointer, and output register at top level (~200-300 RTL lines total).

Verification
REQ-030 Single ALU write: alu rn=5, data=0xDEAD at edge N -> w_en=1, w_rn=5, w_data=0xDEAD during the cycle after N+1, one cycle only.
REQ-031 Simultaneous sources, pointer 0: alu rn=1, mul rn=2, mem rn=3 on one edge -> writes rn 1,2,3 on consecutive cycles, pointer ends at 0.
REQ-032 Zero register: mem rn=0, data=0xFFFF accepted -> w_en stays 0, wb_idle remains 1.
REQ-033 Back-pressure: alu_valid held 4 cycles with mul/mem queues saturated -> alu_ready drops after 2 unretired entries, no entry lost, order 1..4 kept.
REQ-034 Reset mid-burst: assert rst with 5 entries queued -> outputs go to reset values immediately; no w_en after release until new input.
REQ-035 Fairness: all three valids held high for 30 cycles -> each source gets exactly 10 grants, never two consecutive grants to one source.
